// File: rtl/uart_parity_tx.sv
// 8-bit UART transmitter: start, 8 data bits LSB first, parity, stop (8E1; 8O1 with UART_ODD_PARITY_EN).
// All outputs except tx_ready are registered; every non-idle bit lasts CLKS_PER_BIT clocks.
module uart_parity_tx #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       parity_bit
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic             tx_q, busy_q, par_q;
  logic             bit_done, accept, par_new;

  assign bit_done = (baud_q == LAST);
  assign tx_ready = (state_q == IDLE) && !rst;
  assign accept   = tx_valid && tx_ready;

  // Parity bit makes the total ones count over data+parity even (odd when the macro is set).
`ifdef UART_ODD_PARITY_EN
  assign par_new = ~^tx_data;
`else
  assign par_new = ^tx_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      if (state_q != IDLE) baud_q <= bit_done ? '0 : baud_q + 1'b1;
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          idx_q  <= '0;
          if (accept) begin
            shift_q <= tx_data;
            par_q   <= par_new;
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: if (bit_done) begin
          state_q <= DATA;
          tx_q    <= shift_q[0];
        end
        DATA: if (bit_done) begin
          if (idx_q == 3'd7) begin
            state_q <= PARITY;
            tx_q    <= par_q;
            idx_q   <= '0;
          end else begin
            idx_q   <= idx_q + 3'd1;
            shift_q <= shift_q >> 1;
            tx_q    <= shift_q[1];
          end
        end
        PARITY: if (bit_done) begin
          state_q <= STOP;
          tx_q    <= 1'b1;
        end
        STOP: if (bit_done) begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign parity_bit = par_q;

endmodule
